edge_event_counter: RTL
=======================

// Module: edge_event_counter
// PURPOSE
//  Single-clock consumer of a synchronised edge_sync output (dout), sitting directly downstream of it.
//  - Detects rising and/or falling edges on the input.
//  - Counts edges over a programmable window of clock cycles.
//  - Emits one count per window on a valid/ready interface, with saturation and overflow reporting.
// PARAMETERS
//  CNT_W   8   width of event count / cnt_out
//  WIN_W   16  width of window length / internal window counter
//  TS_W    16  timestamp width (used only with EDGE_TSTAMP_EN)
// PORTS
//  clk        in   1      clock
//  rst_n      in   1      synchronous, active-low reset
//  din        in   1      synchronised level (edge_sync dout)
//  en         in   1      1 = run windows; 0 = stop after draining current window
//  edge_sel   in   2      00 none, 01 rise, 10 fall, 11 both; sampled every cycle
//  win_len    in   WIN_W  window length in cycles; 0 treated as 1; sampled at window start
//  cnt_out    out  CNT_W  edge count of the completed window
//  cnt_sat    out  1      count saturated in the window reported on cnt_out
//  cnt_valid  out  1      result valid
//  cnt_ready  in   1      consumer ready
//  ovf        out  1      sticky: a result was dropped
//  clr_ovf    in   1      clears ovf
//  first_ts   out  TS_W   timestamp of first edge in window (EDGE_TSTAMP_EN only)
// BEHAVIOUR
//  Reset: all state registers clear synchronously on clk when rst_n=0 (FSM=IDLE, din_d=0, armed=0, counters=0);
//    outputs cnt_out=0, cnt_sat=0, cnt_valid=0, ovf=0, first_ts=0.
//  Edge detect: din_d <= din. rise = din&~din_d; fall = ~din&din_d; hit = (rise&sel[0])|(fall&sel[1]).
//    armed <= 1 on the first cycle after reset release; hit is forced 0 while armed=0,
//    so there is no spurious edge out of reset.
//  FSM states: IDLE, COUNT, DRAIN.
//    IDLE:  en=1 -> COUNT; win_cnt <= max(win_len,1)-1; ev_cnt <= 0; sat <= 0.
//    COUNT: ev_cnt += hit, saturating at 2^CNT_W-1; sat set when an increment is lost.
//           win_cnt decrements each cycle.
//           At win_cnt==0: result = ev_cnt+hit (saturating) is posted.
//             en=1 -> restart window in the same cycle (no gap cycles; back-to-back windows).
//             en=0 -> IDLE.
//           en falls while win_cnt!=0 -> DRAIN.
//    DRAIN: one cycle; posts the partial-window result, including that cycle's hit; -> IDLE.
//  Latency: result for window cycles [t, t+N-1] appears with cnt_valid=1 in cycle t+N.
//  Post: if cnt_valid=0 or cnt_ready=1 in the post cycle, load cnt_out/cnt_sat/first_ts and set cnt_valid=1.
//    Otherwise drop the new result, keep the old one, and set ovf=1.
//  Handshake: transfer when cnt_valid&cnt_ready.
//    - cnt_out/cnt_sat/first_ts are stable while cnt_valid&~cnt_ready.
//    - After a transfer, cnt_valid clears next cycle unless a post occurs in the same cycle (stays 1, new data).
//  ovf: cleared by clr_ovf; if set and clear occur in the same cycle, set wins.
//  en toggling: en returning to 1 during DRAIN is ignored until IDLE; IDLE->COUNT costs one cycle.
//  Reset mid-window: counts are discarded; no result is posted.
// CONFIGURATION
//  EDGE_TSTAMP_EN defined:
//    - Free-running TS_W counter, reset 0, wraps to 0.
//    - ts_first latches the counter value on the first hit of each window.
//    - If no hit in the window, first_ts = all-ones.
//    - first_ts is posted alongside cnt_out.
//  EDGE_TSTAMP_EN undefined: first_ts port, timestamp counter and latch are absent; all else identical.
// TESTING
//  1. Reset release with din=1 held -> no edge counted; first window (win_len=8, sel=11) gives cnt_out=0.
//  2. din toggles every 2 cycles, sel=01, win_len=16, ready=1 -> cnt_out=4 per window, cnt_valid 1 cycle each, back-to-back.
//  3. Same stimulus, sel=11, CNT_W=3, win_len=40 -> cnt_out=7, cnt_sat=1.
//  4. ready=0 across two window ends -> first result held unchanged, second dropped, ovf=1.
//     Then clr_ovf=1 -> ovf=0; ready=1 -> transfer, cnt_valid drops.
//  5. en dropped 5 cycles into a 16-cycle window with 2 rises seen -> DRAIN posts cnt_out=2, FSM IDLE; win_len=0 -> 1-cycle windows.
//  6. EDGE_TSTAMP_EN: first rise at ts=0x0023 -> first_ts=0x0023; edge-free window -> first_ts=0xFFFF.

Source files
------------

// File: rtl/edge_event_counter.sv
// Windowed edge counter behind an edge synchroniser, valid/ready result port.
// Define EDGE_TSTAMP_EN to add the first-edge timestamp output first_ts.
module edge_event_counter #(
   parameter int CNT_W = 8,
   parameter int WIN_W = 16,
   parameter int TS_W  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             din,
   input  logic             en,
   input  logic [1:0]       edge_sel,
   input  logic [WIN_W-1:0] win_len,
   output logic [CNT_W-1:0] cnt_out,
   output logic             cnt_sat,
   output logic             cnt_valid,
   input  logic             cnt_ready,
   output logic             ovf,
`ifdef EDGE_TSTAMP_EN
   output logic [TS_W-1:0]  first_ts,
`endif
   input  logic             clr_ovf
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] COUNT = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   if (CNT_W < 1 || WIN_W < 1 || TS_W < 1) begin : g_bad_param
      $error("edge_event_counter: widths must be >= 1");
   end

   logic [1:0]       state;
   logic             din_d;
   logic             armed;
   logic             rise;
   logic             fall;
   logic             hit;
   logic [WIN_W-1:0] win_cnt;
   logic [WIN_W-1:0] win_init;
   logic [CNT_W-1:0] ev_cnt;
   logic [CNT_W-1:0] res_cnt;
   logic             sat;
   logic             res_sat;
   logic             full;
   logic             last;
   logic             post;
   logic             start;
   logic             accept;

   assign rise = din & ~din_d;
   assign fall = ~din & din_d;
   assign hit  = armed & ((rise & edge_sel[0]) | (fall & edge_sel[1]));

   assign win_init = (win_len == '0) ? '0 : win_len - WIN_W'(1);

   // The final cycle's hit is folded into the posted result, not into ev_cnt.
   assign full    = &ev_cnt;
   assign res_cnt = (hit & ~full) ? ev_cnt + CNT_W'(1) : ev_cnt;
   assign res_sat = sat | (hit & full);

   assign last   = (state == COUNT) && (win_cnt == '0);
   assign post   = last || (state == DRAIN);
   assign start  = en && ((state == IDLE) || last);
   assign accept = ~cnt_valid | cnt_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         din_d     <= 1'b0;
         armed     <= 1'b0;
         win_cnt   <= '0;
         ev_cnt    <= '0;
         sat       <= 1'b0;
         cnt_out   <= '0;
         cnt_sat   <= 1'b0;
         cnt_valid <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         din_d <= din;
         armed <= 1'b1;

         unique case (state)
            IDLE:    if (en) state <= COUNT;
            COUNT: begin
               if (win_cnt == '0)
                  state <= en ? COUNT : IDLE;
               else if (!en)
                  state <= DRAIN;
            end
            DRAIN:   state <= IDLE;
            default: state <= IDLE;
         endcase

         if (start) begin
            win_cnt <= win_init;
            ev_cnt  <= '0;
            sat     <= 1'b0;
         end else if (state == COUNT) begin
            win_cnt <= win_cnt - WIN_W'(1);
            ev_cnt  <= res_cnt;
            sat     <= res_sat;
         end

         if (post && accept) begin
            cnt_out   <= res_cnt;
            cnt_sat   <= res_sat;
            cnt_valid <= 1'b1;
         end else if (cnt_valid && cnt_ready) begin
            cnt_valid <= 1'b0;
         end

         if (post && !accept)
            ovf <= 1'b1;
         else if (clr_ovf)
            ovf <= 1'b0;
      end
   end

`ifdef EDGE_TSTAMP_EN
   logic [TS_W-1:0] ts;
   logic [TS_W-1:0] ts_first;
   logic [TS_W-1:0] res_ts;
   logic            got;

   assign res_ts = got ? ts_first : (hit ? ts : '1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ts       <= '0;
         ts_first <= '0;
         got      <= 1'b0;
         first_ts <= '0;
      end else begin
         ts <= ts + TS_W'(1);
         if (start) begin
            got <= 1'b0;
         end else if (state == COUNT && hit && !got) begin
            ts_first <= ts;
            got      <= 1'b1;
         end
         if (post && accept)
            first_ts <= res_ts;
      end
   end
`endif

endmodule
